width_downsizer: RTL

//  Single-clock, parametrised N:1 width converter. Buffers IN_W-bit words in a

---
 rtl/width_downsizer.sv | 117 +++++++++++
 1 files changed

// File: rtl/width_downsizer.sv
// Single-clock N:1 width converter: a show-ahead FIFO of IN_W-bit words feeding
// a hold register that is emitted as RATIO lanes of OUT_W bits.
module width_downsizer #(
    parameter int unsigned OUT_W        = 8,
    parameter int unsigned RATIO        = 2,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned MSB_FIRST    = 1,
    parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [OUT_W*RATIO-1:0]       s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [OUT_W-1:0]             m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic [$clog2(DEPTH+1)-1:0]   fill_count,
    output logic                         almost_full,
    output logic                         idle
);

    localparam int unsigned IN_W = OUT_W * RATIO;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned LW   = $clog2(RATIO);

    logic [IN_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_fill;
    logic [IN_W-1:0]  r_hold;
    logic [LW-1:0]    r_lane;
    logic             r_hold_valid;

    logic             w_s_ready;
    logic             w_wr;
    logic             w_is_final;
    logic             w_lane_hs;
    logic             w_final_hs;
    logic             w_pop;
    logic [LW-1:0]    w_sel;
    logic [OUT_W-1:0] w_lane_data;

    // s_ready depends only on registered fill and reset, never on m_ready
    assign w_s_ready  = rst_n & (r_fill != CW'(DEPTH));
    assign w_wr       = s_valid & w_s_ready;
    assign w_is_final = (r_lane == LW'(RATIO - 1));
    assign w_lane_hs  = r_hold_valid & m_ready;
    assign w_final_hs = w_lane_hs & w_is_final;
    assign w_pop      = (r_fill != '0) & (~r_hold_valid | w_final_hs);

    // Lane counter maps to a physical slice of the hold register
    always_comb begin
        w_sel       = (MSB_FIRST != 0) ? (LW'(RATIO - 1) - r_lane) : r_lane;
        w_lane_data = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (LW'(i) == w_sel) begin
                w_lane_data = r_hold[i*OUT_W +: OUT_W];
            end
        end
    end

    // Storage array carries no reset; pointers and fill define what is valid
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_fill <= r_fill + CW'(1);
                2'b01:   r_fill <= r_fill - CW'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Serialiser: reload on final-lane handshake keeps lanes gap-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold       <= '0;
            r_lane       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_pop) begin
            r_hold       <= r_mem[r_rd_ptr];
            r_lane       <= '0;
            r_hold_valid <= 1'b1;
        end else if (w_final_hs) begin
            r_hold_valid <= 1'b0;
        end else if (w_lane_hs) begin
            r_lane <= r_lane + LW'(1);
        end
    end

    assign s_ready     = w_s_ready;
    assign m_data      = w_lane_data;
    assign m_valid     = r_hold_valid;
    assign m_last      = r_hold_valid & w_is_final;
    assign fill_count  = r_fill;
    assign almost_full = (r_fill >= CW'(AFULL_THRESH));
    assign idle        = (r_fill == '0) & ~r_hold_valid;

endmodule
